// File: rtl/xshifter_pipe.sv
// xshifter_pipe: pipelined barrel shifter with valid/ready handshaking.
//
// The shift is split into AW = log2(WIDTH) registered stages. Stage k moves the
// operand by 2^k positions when bit k of the captured shift amount is set. A
// single advance enable moves the whole pipe at once, so a stalled consumer
// freezes every stage and deasserts in_ready.
//
// Ports:
//   clk       - clock, all state updates on the rising edge
//   rst       - synchronous active-high reset
//   in_valid  - request present on in_data/in_amt/in_mode
//   in_ready  - request accepted when in_valid && in_ready
//   in_data   - operand, WIDTH bits
//   in_amt    - shift distance 0..WIDTH-1, AW bits
//   in_mode   - 00 SLL, 01 SRL, 10 SRA, 11 ROR (rotate right)
//   out_valid - out_data/out_zero hold a result
//   out_ready - consumer takes the result when out_valid && out_ready
//   out_data  - shifted result
//   out_zero  - out_data is all zeros
module xshifter_pipe #(
    parameter int unsigned WIDTH = 32,
    localparam int unsigned AW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [AW-1:0]    in_amt,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero
);

    // One stage step: shift d by sh positions according to mode m.
    function automatic logic [WIDTH-1:0] shift_by(input logic [WIDTH-1:0] d,
                                                  input logic [1:0]       m,
                                                  input int unsigned      sh);
        logic [WIDTH-1:0] r;
        case (m)
            2'b00:   r = d << sh;
            2'b01:   r = d >> sh;
            // Arithmetic shift replicates the current MSB, which after any earlier
            // SRA stage is still the operand's sign bit.
            2'b10:   r = $signed(d) >>> sh;
            default: r = (d >> sh) | (d << (WIDTH - sh));
        endcase
        return r;
    endfunction

    logic             adv;
    logic [WIDTH-1:0] data_q   [AW];
    logic [WIDTH-1:0] data_d   [AW];
    logic [WIDTH-1:0] src_data [AW];
    logic [AW-1:0]    amt_q    [AW];
    logic [AW-1:0]    src_amt  [AW];
    logic [1:0]       mode_q   [AW];
    logic [1:0]       src_mode [AW];
    logic [AW-1:0]    valid_q;
    logic [AW-1:0]    src_valid;
    logic             zero_q;
    logic             zero_d;

    assign adv      = !valid_q[AW-1] || out_ready;
    assign in_ready = adv;

    always_comb begin
        // Bubbles enter as all-zero so idle input pins never reach the outputs.
        src_valid[0] = in_valid;
        src_data[0]  = in_valid ? in_data : '0;
        src_amt[0]   = in_valid ? in_amt : '0;
        src_mode[0]  = in_valid ? in_mode : 2'b00;
        for (int k = 1; k < AW; k++) begin
            src_valid[k] = valid_q[k-1];
            src_data[k]  = data_q[k-1];
            src_amt[k]   = amt_q[k-1];
            src_mode[k]  = mode_q[k-1];
        end
        for (int k = 0; k < AW; k++) begin
            data_d[k] = src_amt[k][k] ? shift_by(src_data[k], src_mode[k], 1 << k)
                                      : src_data[k];
        end
        zero_d = (data_d[AW-1] == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            zero_q  <= 1'b1;
            for (int k = 0; k < AW; k++) begin
                data_q[k] <= '0;
                amt_q[k]  <= '0;
                mode_q[k] <= 2'b00;
            end
        end else if (adv) begin
            valid_q <= src_valid;
            zero_q  <= zero_d;
            for (int k = 0; k < AW; k++) begin
                data_q[k] <= data_d[k];
                amt_q[k]  <= src_amt[k];
                mode_q[k] <= src_mode[k];
            end
        end
    end

    assign out_valid = valid_q[AW-1];
    assign out_data  = data_q[AW-1];
    assign out_zero  = zero_q;

endmodule

// File: tb/tb_xshifter_pipe.sv
// tb_xshifter_pipe: directed self-checking bench for xshifter_pipe.
// Drives a WIDTH=32 and a WIDTH=8 instance from one clock and checks results,
// latency, backpressure stalls and mid-flight reset against hand-computed values.
module tb_xshifter_pipe;

    logic        clk;
    logic        rst;

    logic        iv32, ir32, ov32, or32, oz32;
    logic [31:0] id32, od32;
    logic [4:0]  ia32;
    logic [1:0]  im32;

    logic        iv8, ir8, ov8, or8, oz8;
    logic [7:0]  id8, od8;
    logic [2:0]  ia8;
    logic [1:0]  im8;

    int n_vec;
    int n_err;

    localparam logic [31:0] BpData [8] = '{32'h8000_0000, 32'h8000_0000, 32'h0000_0001,
                                           32'h0000_0001, 32'h0000_FFFF, 32'hF000_0000,
                                           32'h1234_5678, 32'hFFFF_0000};
    localparam logic [4:0]  BpAmt  [8] = '{5'd0, 5'd1, 5'd2, 5'd1, 5'd16, 5'd28, 5'd8, 5'd31};
    localparam logic [1:0]  BpMode [8] = '{2'b01, 2'b10, 2'b00, 2'b11, 2'b00, 2'b01, 2'b11,
                                           2'b10};
    localparam logic [31:0] BpExp  [8] = '{32'h8000_0000, 32'hC000_0000, 32'h0000_0004,
                                           32'h8000_0000, 32'hFFFF_0000, 32'h0000_000F,
                                           32'h7812_3456, 32'hFFFF_FFFF};

    xshifter_pipe #(.WIDTH(32)) u_dut32 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (iv32),
        .in_ready  (ir32),
        .in_data   (id32),
        .in_amt    (ia32),
        .in_mode   (im32),
        .out_valid (ov32),
        .out_ready (or32),
        .out_data  (od32),
        .out_zero  (oz32)
    );

    xshifter_pipe #(.WIDTH(8)) u_dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (iv8),
        .in_ready  (ir8),
        .in_data   (id8),
        .in_amt    (ia8),
        .in_mode   (im8),
        .out_valid (ov8),
        .out_ready (or8),
        .out_data  (od8),
        .out_zero  (oz8)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Single request with out_ready high; checks acceptance, latency, data, zero flag.
    task automatic send(input bit w8, input logic [31:0] d, input logic [4:0] a,
                        input logic [1:0] m, input logic [31:0] exp, input logic expz,
                        input string tag);
        int          lat;
        logic [31:0] got;
        logic        z;
        @(negedge clk);
        if (w8) begin
            iv8 = 1'b1; id8 = d[7:0]; ia8 = a[2:0]; im8 = m;
        end else begin
            iv32 = 1'b1; id32 = d; ia32 = a; im32 = m;
        end
        #1;
        check_eq({tag, "_rdy"}, w8 ? ir8 : ir32, 64'd1);
        @(posedge clk);
        #1;
        iv8  = 1'b0;
        iv32 = 1'b0;
        lat  = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (w8 ? ov8 : ov32) begin
                lat = i;
                break;
            end
        end
        got = w8 ? {24'h0, od8} : od32;
        z   = w8 ? oz8 : oz32;
        check_eq({tag, "_lat"}, lat, w8 ? 64'd3 : 64'd5);
        check_eq({tag, "_data"}, got, exp);
        check_eq({tag, "_zero"}, z, expz);
    endtask

    initial begin
        int sent, got, stall, cnt;
        logic [31:0] held;
        n_vec = 0;
        n_err = 0;
        rst = 1'b1;
        iv32 = 1'b0; id32 = '0; ia32 = '0; im32 = '0; or32 = 1'b1;
        iv8  = 1'b0; id8  = '0; ia8  = '0; im8  = '0; or8  = 1'b1;

        // Reset state
        @(posedge clk);
        @(negedge clk);
        check_eq("rst_valid", ov32, 64'd0);
        check_eq("rst_data", od32, 64'd0);
        check_eq("rst_zero", oz32, 64'd1);
        check_eq("rst_valid8", ov8, 64'd0);
        check_eq("rst_zero8", oz8, 64'd1);
        rst = 1'b0;
        #1;
        check_eq("rst_ready", ir32, 64'd1);

        // Idle inputs with in_valid low must not disturb outputs
        id32 = 32'hDEAD_BEEF; ia32 = 5'd7; im32 = 2'b11;
        repeat (8) @(negedge clk);
        check_eq("idle_valid", ov32, 64'd0);
        check_eq("idle_data", od32, 64'd0);
        check_eq("idle_zero", oz32, 64'd1);

        // WIDTH=32 directed vectors
        send(1'b0, 32'h0000_0002, 5'd10, 2'b00, 32'h0000_0800, 1'b0, "sll10");
        send(1'b0, 32'h0000_002F, 5'd5,  2'b01, 32'h0000_0001, 1'b0, "srl5");
        send(1'b0, 32'h8000_0000, 5'd4,  2'b10, 32'hF800_0000, 1'b0, "sra4");
        send(1'b0, 32'h7FFF_FFFF, 5'd31, 2'b10, 32'h0000_0000, 1'b1, "sra31");
        send(1'b0, 32'h0000_000F, 5'd4,  2'b11, 32'hF000_0000, 1'b0, "ror4");
        send(1'b0, 32'h0000_0000, 5'd3,  2'b11, 32'h0000_0000, 1'b1, "ror_zero");
        send(1'b0, 32'h1234_5678, 5'd0,  2'b00, 32'h1234_5678, 1'b0, "amt0_sll");
        send(1'b0, 32'h1234_5678, 5'd0,  2'b01, 32'h1234_5678, 1'b0, "amt0_srl");
        send(1'b0, 32'h1234_5678, 5'd0,  2'b10, 32'h1234_5678, 1'b0, "amt0_sra");
        send(1'b0, 32'h1234_5678, 5'd0,  2'b11, 32'h1234_5678, 1'b0, "amt0_ror");

        // WIDTH=8 instance
        send(1'b1, 32'h81, 5'd1, 2'b00, 32'h02, 1'b0, "w8_sll");
        send(1'b1, 32'h81, 5'd1, 2'b01, 32'h40, 1'b0, "w8_srl");
        send(1'b1, 32'h81, 5'd1, 2'b10, 32'hC0, 1'b0, "w8_sra");
        send(1'b1, 32'h81, 5'd1, 2'b11, 32'hC0, 1'b0, "w8_ror");
        send(1'b1, 32'h81, 5'd7, 2'b01, 32'h01, 1'b0, "w8_srl7");

        // Backpressure: 8 back-to-back requests, 3-cycle stall at first result
        sent  = 0;
        got   = 0;
        stall = 0;
        held  = '0;
        for (int cyc = 0; cyc < 100 && got < 8; cyc++) begin
            @(negedge clk);
            if (sent < 8) begin
                iv32 = 1'b1; id32 = BpData[sent]; ia32 = BpAmt[sent]; im32 = BpMode[sent];
            end else begin
                iv32 = 1'b0;
            end
            or32 = !(ov32 && stall < 3);
            #1;
            if (!or32) begin
                stall++;
                check_eq("bp_in_ready", ir32, 64'd0);
                if (stall == 1) held = od32;
                else check_eq("bp_hold", od32, held);
            end
            if (iv32 && ir32) sent++;
            if (ov32 && or32) begin
                check_eq($sformatf("bp_res%0d", got), od32, BpExp[got]);
                got++;
            end
        end
        iv32 = 1'b0;
        or32 = 1'b1;
        check_eq("bp_count", got, 64'd8);
        check_eq("bp_stalls", stall, 64'd3);
        cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (ov32) cnt++;
        end
        check_eq("bp_nodup", cnt, 64'd0);

        // Reset mid-flight: 3 accepted requests are discarded
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            iv32 = 1'b1; id32 = 32'h0000_0001 << i; ia32 = 5'd1; im32 = 2'b00;
        end
        @(negedge clk);
        rst  = 1'b1;
        id32 = 32'h0000_00FF;
        @(negedge clk);
        rst  = 1'b0;
        iv32 = 1'b0;
        #1;
        check_eq("mid_rst_ready", ir32, 64'd1);
        check_eq("mid_rst_valid", ov32, 64'd0);
        check_eq("mid_rst_zero", oz32, 64'd1);
        cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (ov32) cnt++;
        end
        check_eq("mid_rst_flush", cnt, 64'd0);
        check_eq("mid_rst_zero2", oz32, 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
